llc_pipe_fifo: RTL and testbench

//  Parametrised valid/ready FIFO; inter-stage buffer of the LLC pipeline (decode->mem, mem->lookup, lookup->process).

---
 rtl/llc_pipe_fifo_pkg.sv | 13 +
 rtl/llc_pipe_fifo_ctrl.sv | 92 +++++++++
 rtl/llc_pipe_fifo.sv | 66 ++++++
 tb/tb_llc_pipe_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/llc_pipe_fifo_pkg.sv
// Shared constants for the LLC inter-stage FIFO.
// Default geometry plus the pointer-width helper used by the top and its controller.
package llc_pipe_fifo_pkg;

    localparam int LLC_FIFO_DEPTH = 4;
    localparam int LLC_FIFO_WIDTH = 32;

    // A single-entry FIFO still needs a one-bit pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/llc_pipe_fifo_ctrl.sv
// Pointer/usage/flag controller for llc_pipe_fifo; bypass gated by LLC_PIPE_FIFO_BYPASS_EN.
// Latency: flags and pointers update on the edge that takes the push/pop.
// Backpressure: in_ready depends only on fullness, flush and reset, never on out_ready.
module llc_pipe_fifo_ctrl
    import llc_pipe_fifo_pkg::*;
#(
    parameter int  DEPTH        = LLC_FIFO_DEPTH,
    parameter int  AFULL_THRESH = DEPTH - 1,
    localparam int CNT_W        = $clog2(DEPTH + 1),
    localparam int PTR_W        = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic             out_ready,
    output logic             in_ready,
    output logic             out_valid,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] usage,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             err
);

    logic           at_full;
    logic           at_empty;
    logic           byp;
    logic           pop;
    logic           mismatch;
    logic [PTR_W:0] span;

    assign at_full  = (usage == CNT_W'(DEPTH));
    assign at_empty = (usage == '0);

`ifdef LLC_PIPE_FIFO_BYPASS_EN
    assign byp = rst && !flush && at_empty && in_valid && out_ready;
`else
    assign byp = 1'b0;
`endif

    assign in_ready    = rst && !flush && !at_full;
    assign out_valid   = rst && !flush && (!at_empty || byp);
    // A bypassed word goes straight to the consumer and is never stored.
    assign wr_en       = in_valid && in_ready && !byp;
    assign pop         = rst && !flush && !at_empty && out_ready;
    assign full        = rst && at_full;
    assign empty       = !rst || at_empty;
    assign almost_full = rst ? (32'(usage) >= 32'(AFULL_THRESH)) : (AFULL_THRESH == 0);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer distance must agree with usage; when full the pointers coincide.
    always_comb begin
        span     = '0;
        mismatch = 1'b0;
        if (wr_ptr >= rd_ptr) begin
            span = {1'b0, wr_ptr} - {1'b0, rd_ptr};
        end else begin
            span = {1'b0, wr_ptr} + (PTR_W + 1)'(DEPTH) - {1'b0, rd_ptr};
        end
        mismatch = at_full ? (span != '0) : (32'(span) != 32'(usage));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
            err    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usage  <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            if (wr_en && !pop) begin
                usage <= usage + CNT_W'(1);
            end else if (pop && !wr_en) begin
                usage <= usage - CNT_W'(1);
            end
            if (mismatch) err <= 1'b1;
        end
    end

endmodule

// File: rtl/llc_pipe_fifo.sv
// Generic valid/ready buffer between LLC pipeline stages; optional empty bypass via LLC_PIPE_FIFO_BYPASS_EN.
// Latency: 1 cycle push-to-head (0 cycles when bypassing an empty FIFO).
// Backpressure: in_ready drops when full, in flush or in reset; a same-cycle pop does not free a slot.
module llc_pipe_fifo
    import llc_pipe_fifo_pkg::*;
#(
    parameter int  WIDTH        = LLC_FIFO_WIDTH,
    parameter int  DEPTH        = LLC_FIFO_DEPTH,
    parameter int  AFULL_THRESH = DEPTH - 1,
    localparam int CNT_W        = $clog2(DEPTH + 1),
    localparam int PTR_W        = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] usage,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             err
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    llc_pipe_fifo_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL_THRESH)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .out_ready   (out_ready),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .wr_en       (wr_en),
        .wr_ptr      (wr_ptr),
        .rd_ptr      (rd_ptr),
        .usage       (usage),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .err         (err)
    );

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= in_data;
    end

`ifdef LLC_PIPE_FIFO_BYPASS_EN
    assign out_data = empty ? in_data : mem[rd_ptr];
`else
    assign out_data = mem[rd_ptr];
`endif

endmodule

// File: tb/tb_llc_pipe_fifo.sv
// Bench for llc_pipe_fifo: DEPTH=4 and DEPTH=3 instances checked every cycle against a queue model,
// plus directed sequences with literal expectations.
module tb_llc_pipe_fifo;

`ifdef LLC_PIPE_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        iv   [2];
    logic        ordy [2];
    logic [31:0] id   [2];
    logic        ir   [2];
    logic        ov   [2];
    logic [31:0] od   [2];
    logic [31:0] use_w[2];
    logic        fl   [2];
    logic        em   [2];
    logic        af   [2];
    logic        er   [2];
    bit          started = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int D  = (g == 0) ? 4 : 3;
        localparam int AF = D - 1;
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] u;
        logic [31:0]   q[$];

        llc_pipe_fifo #(.WIDTH(32), .DEPTH(D)) dut (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .in_valid    (iv[g]),
            .in_ready    (ir[g]),
            .in_data     (id[g]),
            .out_valid   (ov[g]),
            .out_ready   (ordy[g]),
            .out_data    (od[g]),
            .usage       (u),
            .full        (fl[g]),
            .empty       (em[g]),
            .almost_full (af[g]),
            .err         (er[g])
        );
        assign use_w[g] = 32'(u);

        // Model: a queue holding the words the FIFO must contain.
        always @(posedge clk) begin
            if (!rst || flush) begin
                q.delete();
            end else begin
                bit byp, push, pop;
                byp  = BYP && q.size() == 0 && iv[g] && ordy[g];
                push = iv[g] && q.size() < D && !byp;
                pop  = q.size() > 0 && ordy[g];
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(id[g]);
            end
        end

        always @(negedge clk) begin
            if (started) begin
                int n;
                bit e_byp, e_ov;
                n     = q.size();
                e_byp = BYP && rst && !flush && n == 0 && iv[g] && ordy[g];
                e_ov  = rst && !flush && (n > 0 || e_byp);
                chk($sformatf("d%0d in_ready", g), 32'(ir[g]), 32'(rst && !flush && n < D));
                chk($sformatf("d%0d out_valid", g), 32'(ov[g]), 32'(e_ov));
                if (e_ov) chk($sformatf("d%0d out_data", g), od[g], (n > 0) ? q[0] : id[g]);
                chk($sformatf("d%0d usage", g), use_w[g], 32'(n));
                chk($sformatf("d%0d full", g), 32'(fl[g]), 32'(rst && n == D));
                chk($sformatf("d%0d empty", g), 32'(em[g]), 32'(!rst || n == 0));
                chk($sformatf("d%0d almost_full", g), 32'(af[g]), 32'(rst ? (n >= AF) : (AF == 0)));
                chk($sformatf("d%0d err", g), 32'(er[g]), 32'(0));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; id[i] = '0;
        end

        // 1: reset for 3 cycles, then release
        @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        chk("t1 rst in_ready", 32'(ir[0]), 0);
        chk("t1 rst empty", 32'(em[0]), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t1 in_ready", 32'(ir[0]), 1);
        chk("t1 out_valid", 32'(ov[0]), 0);
        chk("t1 usage", use_w[0], 0);
        chk("t1 err", 32'(er[0]), 0);
        tick();

        // 2: fill DEPTH=4, refuse 5th, drain in order
        iv[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            id[0] = 32'hA1 + 32'(k);
            @(negedge clk);
            chk("t2 usage", use_w[0], 32'(k));
            chk("t2 almost_full", 32'(af[0]), 32'(k >= 3));
            tick();
        end
        id[0] = 32'hA5;
        @(negedge clk);
        chk("t2 full", 32'(fl[0]), 1);
        chk("t2 in_ready", 32'(ir[0]), 0);
        tick();
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2 pop data", od[0], 32'hA1 + 32'(k));
            tick();
        end
        ordy[0] = 1'b0;
        @(negedge clk);
        chk("t2 drained empty", 32'(em[0]), 1);
        tick();

        // 3: DEPTH=3 steady push+pop at usage 1
        iv[1] = 1'b1;
        id[1] = 32'hB00;
        tick();
        ordy[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            id[1] = 32'hB00 + 32'(k);
            @(negedge clk);
            chk("t3 usage", use_w[1], 1);
            chk("t3 head", od[1], 32'hB00 + 32'(k - 1));
            tick();
        end
        iv[1] = 1'b0;
        @(negedge clk);
        chk("t3 last", od[1], 32'hB0A);
        tick();
        ordy[1] = 1'b0;
        @(negedge clk);
        chk("t3 empty", 32'(em[1]), 1);

        // 4: flush at usage 2 with a concurrent push
        iv[0] = 1'b1;
        id[0] = 32'hC1;
        tick();
        id[0] = 32'hC2;
        tick();
        flush = 1'b1;
        id[0] = 32'hC3;
        @(negedge clk);
        chk("t4 flush in_ready", 32'(ir[0]), 0);
        chk("t4 flush out_valid", 32'(ov[0]), 0);
        tick();
        flush = 1'b0;
        iv[0] = 1'b0;
        @(negedge clk);
        chk("t4 usage", use_w[0], 0);
        chk("t4 empty", 32'(em[0]), 1);
        iv[0] = 1'b1;
        id[0] = 32'hC4;
        tick();
        iv[0] = 1'b0;
        @(negedge clk);
        chk("t4 head after flush", od[0], 32'hC4);
        ordy[0] = 1'b1;
        tick();
        ordy[0] = 1'b0;

        // 5: reset mid-stream at usage 3
        iv[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            id[0] = 32'hD1 + 32'(k);
            tick();
        end
        iv[0] = 1'b0;
        @(negedge clk);
        chk("t5 usage before rst", use_w[0], 3);
        rst = 1'b0;
        @(negedge clk);
        chk("t5 rst out_valid", 32'(ov[0]), 0);
        tick();
        @(negedge clk);
        chk("t5 usage after rst", use_w[0], 0);
        rst = 1'b1;
        iv[0] = 1'b1;
        id[0] = 32'hE1;
        tick();
        id[0] = 32'hE2;
        tick();
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("t5 first post-rst", od[0], 32'hE1);
        tick();
        tick();
        ordy[0] = 1'b0;

        // 6: empty FIFO, push with consumer ready
        @(negedge clk);
        chk("t6 start empty", 32'(em[0]), 1);
        iv[0] = 1'b1;
        id[0] = 32'h5C;
        ordy[0] = 1'b1;
        #1;
        chk("t6 same-cycle out_valid", 32'(ov[0]), 32'(BYP));
        if (BYP) chk("t6 bypass data", od[0], 32'h5C);
        tick();
        iv[0] = 1'b0;
        @(negedge clk);
        chk("t6 next out_valid", 32'(ov[0]), 32'(!BYP));
        chk("t6 next usage", use_w[0], 32'(!BYP));
        if (!BYP) chk("t6 next data", od[0], 32'h5C);
        tick();
        ordy[0] = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
